// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, scheduler state encoding and rotate helper
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS = 64;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
endpackage

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: combinational SHA-256 small sigma (SEL 0 = s0, 1 = s1)
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter bit SEL = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);
  assign y = SEL ? (rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10)) : (rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3));
endmodule

// File: rtl/sha256_message_scheduler.sv
// sha256_message_scheduler: loads a 16-word block and streams W[0..63] from a 16-entry ring
module sha256_message_scheduler
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] msg_word,
  input  logic              msg_word_valid,
  output logic              msg_word_ready,
  output logic [WORD_W-1:0] wt,
  output logic              wt_valid,
  input  logic              wt_ready,
  output logic [5:0]        round_idx,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [WORD_W-1:0] mem [BLOCK_WORDS];
  logic [3:0] cnt;
  logic [5:0] t;
  logic acc, xfer;
  logic [WORD_W-1:0] s0, s1;
  sha256_small_sigma #(.SEL(1'b0)) u_s0 (.x(mem[t[3:0] + 4'd1]), .y(s0));
  sha256_small_sigma #(.SEL(1'b1)) u_s1 (.x(mem[t[3:0] + 4'd14]), .y(s1));
  // Slot t&15 still holds W[t-16] until this round's word overwrites it
  assign wt = (t < 6'(BLOCK_WORDS)) ? mem[t[3:0]] : s1 + mem[t[3:0] + 4'd9] + s0 + mem[t[3:0]];
  assign round_idx = t;
  always_comb begin
    msg_word_ready = state == LOAD;
    wt_valid = state == RUN;
    busy = state == LOAD || state == RUN;
    done = state == DONE;
    acc = msg_word_ready & msg_word_valid;
    xfer = wt_valid & wt_ready;
    state_n = (state == IDLE && start) ? LOAD :
              (acc && cnt == 4'(BLOCK_WORDS - 1)) ? RUN :
              (xfer && t == 6'(ROUNDS - 1)) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
      cnt <= '0;
      t <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        t <= '0;
      end
      if (acc) begin
        mem[cnt] <= msg_word;
        cnt <= cnt + 4'd1;
      end
      if (xfer) begin
        if (t >= 6'(BLOCK_WORDS)) mem[t[3:0]] <= wt;
        t <= t + 6'd1;
      end
    end
endmodule

// File: doc/sha256_message_scheduler.md
SHA256_MESSAGE_SCHEDULER -- requirements
Module: sha256_message_scheduler

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  begin loading a new 512-bit block; sampled in IDLE only.
REQ-004 SHALL have port msg_word  input  32  message word M[i], word 0 first (big-endian block order).
REQ-005 SHALL have port msg_word_valid  input  1  msg_word is valid.
REQ-006 SHALL have port msg_word_ready  output  1  scheduler accepts a word this cycle.
REQ-007 SHALL have port wt  output  32  schedule word W[t] for the compression round.
REQ-008 SHALL have port wt_valid  output  1  wt and round_idx are valid.
REQ-009 SHALL have port wt_ready  input  1  compression logic consumes wt this cycle.
REQ-010 SHALL have port round_idx  output  6  current t, 0..63.
REQ-011 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse after W[63] is transferred.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-014 SHALL go IDLE->LOAD when start=1, clearing load counter to 0.
REQ-015 SHALL assert msg_word_ready=1 only in LOAD; a word is accepted when msg_word_valid & msg_word_ready and written to buf[cnt], cnt increments.
REQ-016 SHALL go LOAD->RUN on acceptance of the 16th word, t=0; first wt_valid=1 the next cycle.
REQ-017 SHALL hold wt_valid=1 throughout RUN and 0 in all other states.
REQ-018 SHALL drive wt=buf[t] for t<16.
REQ-019 SHALL drive wt=(s1(buf[(t+14)&15]) + buf[(t+9)&15] + s0(buf[(t+1)&15]) + buf[t&15]) mod 2^32 for t>=16, carries above bit 31 discarded.
REQ-020 SHALL define s0(x)=ROTR7(x)^ROTR18(x)^SHR3(x) and s1(x)=ROTR17(x)^ROTR19(x)^SHR10(x).
REQ-021 SHALL, on wt_valid & wt_ready with t>=16, write wt into buf[t&15]; for any t, increment t.
REQ-022 SHALL keep wt, round_idx and buf unchanged while wt_ready=0 (stall of any length).
REQ-023 SHALL go RUN->DONE on transfer at t=63, assert done=1 for exactly that DONE cycle, then go to IDLE.
REQ-024 SHALL ignore start outside IDLE (including the DONE cycle) and ignore msg_word_valid outside LOAD.
REQ-025 SHALL add zero latency from buffer/t to wt (combinational output path from registered state).

Reset
REQ-026 SHALL, on rst=1 at any time (including mid-LOAD or mid-RUN), enter IDLE immediately, abandoning the block.
REQ-027 SHALL reset outputs to msg_word_ready=0, wt_valid=0, busy=0, done=0, round_idx=0, wt=0, and clear buf and counters to 0.

Structure
REQ-028 SHALL take WORD_W=32, BLOCK_WORDS=16, ROUNDS=64 and the state enumeration from shared package sha256_pkg.
REQ-029 SHALL instantiate sub-module sha256_small_sigma (parameter SEL: 0=s0, 1=s1), twice, purely combinational.
REQ-030 SHALL use a 16-entry x 32-bit circular buffer; no 64-entry storage.

Verification
REQ-031 SHALL test the "abc" block (W0=61626380, W1..W14=0, W15=00000018) -> W16=61626380, W17=000F0000, W18=7DA86405, W63=12B1EDEB, done pulse once.
REQ-032 SHALL test a block with W1=00000001, all others 0 -> W16=02004000.
REQ-033 SHALL test all-zero block -> all 64 wt=00000000, round_idx 0..63 in order.
REQ-034 SHALL test random wt_ready stalls on "abc" -> identical W sequence, wt stable during every stall.
REQ-035 SHALL test rst asserted at round_idx=20 -> next cycle wt_valid=0, busy=0; a new "abc" load then reproduces REQ-031 values.
REQ-036 SHALL test start pulsed during LOAD, RUN and the DONE cycle -> ignored; msg_word_valid during RUN -> no buffer change.
